// File: rtl/riscv_ctrl_pkg.sv
// Shared state encodings, opcodes and control-word layout for the multicycle
// RISC-V controller and the datapath bench.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       adrsrc;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       pcupdate;
        logic       branch;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_word_t;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath control bus; the controller sits on the slave side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pcwrite;
    logic       adrsrc;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] immsrc;
    logic       illegal;
    logic [3:0] state;

    modport slave (
        input  op, zero, mem_ready,
        output pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc,
               alusrca, alusrcb, aluop, immsrc, illegal, state
    );

    modport master (
        output op, zero, mem_ready,
        input  pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc,
               alusrca, alusrcb, aluop, immsrc, illegal, state
    );
endinterface

// File: rtl/mc_ctrl_word.sv
// Moore output decode: maps the controller state (and mem_ready in FETCH)
// to the datapath control word.
module mc_ctrl_word
    import riscv_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic       rdy_i,
    output ctrl_word_t cw_o
);

    // Control word lookup; anything not set stays 0, which also covers ILLEGAL.
    always_comb begin
        cw_o = '0;
        case (state_i)
            S_FETCH: begin
                cw_o.alusrcb   = 2'b10;
                cw_o.resultsrc = 2'b10;
                cw_o.irwrite   = rdy_i;
                cw_o.pcupdate  = rdy_i;
            end
            S_DECODE: begin
                cw_o.alusrca = 2'b01;
                cw_o.alusrcb = 2'b01;
            end
            S_MEMADR: begin
                cw_o.alusrca = 2'b10;
                cw_o.alusrcb = 2'b01;
            end
            S_EXECUTEI: begin
                cw_o.alusrca = 2'b10;
                cw_o.alusrcb = 2'b01;
                cw_o.aluop   = 2'b10;
            end
            S_MEMREAD: begin
                cw_o.adrsrc = 1'b1;
            end
            S_MEMWRITE: begin
                cw_o.adrsrc   = 1'b1;
                cw_o.memwrite = 1'b1;
            end
            S_MEMWB: begin
                cw_o.resultsrc = 2'b01;
                cw_o.regwrite  = 1'b1;
            end
            S_ALUWB: begin
                cw_o.regwrite = 1'b1;
            end
            S_EXECUTER: begin
                cw_o.alusrca = 2'b10;
                cw_o.aluop   = 2'b10;
            end
            S_JAL: begin
                cw_o.alusrca  = 2'b01;
                cw_o.alusrcb  = 2'b10;
                cw_o.pcupdate = 1'b1;
            end
            S_BEQ: begin
                cw_o.alusrca = 2'b10;
                cw_o.aluop   = 2'b01;
                cw_o.branch  = 1'b1;
            end
            default: cw_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: state register, next-state logic and the
// sticky illegal-opcode flag; outputs come from mc_ctrl_word.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.slave  bus
);

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       rdy_s;
    ctrl_word_t cw_s;

    assign rdy_s = USE_MEM_READY ? bus.mem_ready : 1'b1;

    // State and illegal flag registers, cleared asynchronously by rst low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state sequencing; memory states stall until rdy_s.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (rdy_s) state_d = S_DECODE;
                else       state_d = S_FETCH;
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_SW) state_d = S_MEMWRITE;
                else                 state_d = S_MEMREAD;
            end
            S_MEMREAD: begin
                if (rdy_s) state_d = S_MEMWB;
                else       state_d = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (rdy_s) state_d = S_FETCH;
                else       state_d = S_MEMWRITE;
            end
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ:       state_d = S_FETCH;
            S_ILLEGAL:                     state_d = S_ILLEGAL;
            default:                       state_d = S_FETCH;
        endcase
        // Flag rises together with the entry into ILLEGAL and sticks until reset.
        if (state_d == S_ILLEGAL) illegal_d = 1'b1;
        else                      illegal_d = illegal_q;
    end

    mc_ctrl_word u_ctrl_word (
        .state_i (state_q),
        .rdy_i   (rdy_s),
        .cw_o    (cw_s)
    );

    assign bus.pcwrite   = cw_s.pcupdate | (cw_s.branch & bus.zero);
    assign bus.adrsrc    = cw_s.adrsrc;
    assign bus.irwrite   = cw_s.irwrite;
    assign bus.memwrite  = cw_s.memwrite;
    assign bus.regwrite  = cw_s.regwrite;
    assign bus.resultsrc = cw_s.resultsrc;
    assign bus.alusrca   = cw_s.alusrca;
    assign bus.alusrcb   = cw_s.alusrcb;
    assign bus.aluop     = cw_s.aluop;
    assign bus.immsrc    = imm_src(bus.op);
    assign bus.illegal   = illegal_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected per-cycle states are
// queued per instruction and compared, with the control word, on each negedge.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller #(.USE_MEM_READY(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        state_t st;
        logic   rdy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference control word, packed as {pcwrite,adrsrc,irwrite,memwrite,regwrite,
    // resultsrc,alusrca,alusrcb,aluop,immsrc,illegal}.
    function automatic logic [15:0] exp_out(input state_t st, input logic rdy,
                                            input logic z, input logic [6:0] op);
        logic pcupd, br, adr, irw, mw, rw, ill;
        logic [1:0] res, a, b, alu, imm;
        pcupd = 1'b0; br = 1'b0; adr = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0;
        res = 2'b00; a = 2'b00; b = 2'b00; alu = 2'b00;
        ill = (st == S_ILLEGAL);
        if (op == 7'b0100011)      imm = 2'b01;
        else if (op == 7'b1100011) imm = 2'b10;
        else if (op == 7'b1101111) imm = 2'b11;
        else                       imm = 2'b00;
        case (st)
            S_FETCH:    begin b = 2'b10; res = 2'b10; irw = rdy; pcupd = rdy; end
            S_DECODE:   begin a = 2'b01; b = 2'b01; end
            S_MEMADR:   begin a = 2'b10; b = 2'b01; end
            S_EXECUTEI: begin a = 2'b10; b = 2'b01; alu = 2'b10; end
            S_MEMREAD:  begin adr = 1'b1; end
            S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
            S_MEMWB:    begin res = 2'b01; rw = 1'b1; end
            S_ALUWB:    begin rw = 1'b1; end
            S_EXECUTER: begin a = 2'b10; alu = 2'b10; end
            S_JAL:      begin a = 2'b01; b = 2'b10; pcupd = 1'b1; end
            S_BEQ:      begin a = 2'b10; alu = 2'b01; br = 1'b1; end
            default:    ;
        endcase
        return {pcupd | (br & z), adr, irw, mw, rw, res, a, b, alu, imm, ill};
    endfunction

    function automatic logic [15:0] dut_out();
        return {bus.pcwrite, bus.adrsrc, bus.irwrite, bus.memwrite, bus.regwrite,
                bus.resultsrc, bus.alusrca, bus.alusrcb, bus.aluop, bus.immsrc, bus.illegal};
    endfunction

    task automatic push(input state_t st, input logic rdy, input int n);
        exp_t e;
        e.st  = st;
        e.rdy = rdy;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic drain(input logic [6:0] op, input logic z);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            bus.op        = op;
            bus.zero      = z;
            bus.mem_ready = e.rdy;
            #1;
            check_eq($sformatf("state op=%b exp=%s", op, e.st.name()), 32'(bus.state), 32'(e.st));
            check_eq($sformatf("ctrl op=%b st=%s", op, e.st.name()), 32'(dut_out()),
                     32'(exp_out(e.st, e.rdy, z, op)));
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic z, input int fwait, input int mwait);
        push(S_FETCH, 1'b0, fwait);
        push(S_FETCH, 1'b1, 1);
        push(S_DECODE, 1'b1, 1);
        case (op)
            7'b0000011: begin
                push(S_MEMADR, 1'b1, 1);
                push(S_MEMREAD, 1'b0, mwait);
                push(S_MEMREAD, 1'b1, 1);
                push(S_MEMWB, 1'b1, 1);
            end
            7'b0100011: begin
                push(S_MEMADR, 1'b1, 1);
                push(S_MEMWRITE, 1'b0, mwait);
                push(S_MEMWRITE, 1'b1, 1);
            end
            7'b0110011: begin push(S_EXECUTER, 1'b1, 1); push(S_ALUWB, 1'b1, 1); end
            7'b0010011: begin push(S_EXECUTEI, 1'b1, 1); push(S_ALUWB, 1'b1, 1); end
            7'b1101111: begin push(S_JAL, 1'b1, 1); push(S_ALUWB, 1'b1, 1); end
            7'b1100011: begin push(S_BEQ, 1'b1, 1); end
            default:    begin push(S_ILLEGAL, 1'b1, 20); end
        endcase
        drain(op, z);
    endtask

    initial begin
        rst           = 1'b0;
        bus.op        = 7'b0000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_state", 32'(bus.state), 32'(S_FETCH));
        check_eq("reset_ctrl", 32'(dut_out()), 32'(exp_out(S_FETCH, 1'b0, 1'b0, 7'b0000000)));
        #1 rst = 1'b1;

        run_instr(7'b0000011, 1'b0, 0, 0);   // lw, 5 cycles
        run_instr(7'b0000011, 1'b1, 2, 2);   // lw with fetch and read stalls
        run_instr(7'b0100011, 1'b0, 0, 3);   // sw, memwrite held 4 cycles
        run_instr(7'b0110011, 1'b0, 0, 0);
        run_instr(7'b0010011, 1'b1, 1, 0);
        run_instr(7'b1101111, 1'b0, 0, 0);
        run_instr(7'b1100011, 1'b1, 0, 0);   // beq taken
        run_instr(7'b1100011, 1'b0, 0, 0);   // beq not taken

        // Reset in the middle of a stalled store.
        push(S_FETCH, 1'b1, 1);
        push(S_DECODE, 1'b1, 1);
        push(S_MEMADR, 1'b1, 1);
        push(S_MEMWRITE, 1'b0, 1);
        drain(7'b0100011, 1'b0);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_mw_memwrite", 32'(bus.memwrite), 32'd0);
        check_eq("rst_mw_state", 32'(bus.state), 32'(S_FETCH));
        check_eq("rst_mw_wr_en", 32'({bus.regwrite, bus.pcwrite}), 32'd0);
        bus.mem_ready = 1'b0;
        #1 rst = 1'b1;

        run_instr(7'b0110011, 1'b0, 0, 0);
        run_instr(7'b1111111, 1'b0, 0, 0);   // illegal op, 20 cycles in ILLEGAL

        @(negedge clk);
        bus.mem_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_eq("ill_rst_state", 32'(bus.state), 32'(S_FETCH));
        check_eq("ill_rst_flag", 32'(bus.illegal), 32'd0);
        #1 rst = 1'b1;

        run_instr(7'b1101111, 1'b1, 0, 0);
        run_instr(7'b0100011, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter: USE_MEM_READY, 1, when 0 the controller ignores mem_ready and treats it as 1.
REQ-002 SHALL have port: clk  input  1  single clock, rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: op  input  7  opcode of the instruction register, valid from DECODE onward.
REQ-005 SHALL have port: zero  input  1  ALU zero flag.
REQ-006 SHALL have port: mem_ready  input  1  memory access completes this cycle.
REQ-007 SHALL have port: pcwrite  output  1  PC load enable (pcupdate | (branch & zero)).
REQ-008 SHALL have port: adrsrc  output  1  memory address select: 0=PC, 1=ALU result register.
REQ-009 SHALL have port: irwrite  output  1  instruction register / oldPC load enable.
REQ-010 SHALL have port: memwrite  output  1  data memory write strobe.
REQ-011 SHALL have port: regwrite  output  1  register file write enable.
REQ-012 SHALL have port: resultsrc  output  2  result select: 00=ALUOut, 01=memory data, 10=ALU result.
REQ-013 SHALL have port: alusrca  output  2  ALU A select: 00=PC, 01=oldPC, 10=rs1.
REQ-014 SHALL have port: alusrcb  output  2  ALU B select: 00=rs2, 01=imm, 10=constant 4.
REQ-015 SHALL have port: aluop  output  2  ALU operation class: 00=add, 01=sub, 10=funct-decoded.
REQ-016 SHALL have port: immsrc  output  2  immediate format: 00=I, 01=S, 10=B, 11=J.
REQ-017 SHALL have port: illegal  output  1  sticky flag for an unsupported opcode.

Function
REQ-018 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ and ILLEGAL.
REQ-019 SHALL sequence FETCH->DECODE only when mem_ready=1; otherwise it SHALL hold in FETCH.
REQ-020 SHALL branch from DECODE on op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1101111->JAL, 1100011->BEQ, any other op->ILLEGAL.
REQ-021 SHALL branch from MEMADR to MEMREAD for lw and to MEMWRITE for sw.
REQ-022 SHALL sequence MEMREAD->MEMWB when mem_ready=1, and MEMWB->FETCH.
REQ-023 SHALL hold memwrite=1 in MEMWRITE until mem_ready=1, then go to FETCH.
REQ-024 SHALL sequence EXECUTER, EXECUTEI and JAL to ALUWB, and ALUWB->FETCH; BEQ SHALL go to FETCH.
REQ-025 SHALL drive these control words (unlisted outputs 0):
- FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10; irwrite and pcupdate = mem_ready.
- DECODE: alusrca=01, alusrcb=01, aluop=00.
- MEMADR and EXECUTEI: alusrca=10, alusrcb=01; aluop=00 in MEMADR, 10 in EXECUTEI.
- MEMREAD: adrsrc=1, resultsrc=00.
- MEMWRITE: adrsrc=1.
- MEMWB: resultsrc=01, regwrite=1.
- ALUWB: resultsrc=00, regwrite=1.
- EXECUTER: alusrca=10, alusrcb=00, aluop=10.
- JAL: alusrca=01, alusrcb=10, resultsrc=00, pcupdate=1.
- BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1.
REQ-026 SHALL decode immsrc combinationally from op: sw->01, beq->10, jal->11, all others->00.
REQ-027 SHALL take these latencies with mem_ready held at 1: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3 cycles (FETCH to FETCH).
REQ-028 SHALL set illegal=1 in ILLEGAL, hold every enable at 0 there, and remain in ILLEGAL until reset.
REQ-029 SHALL ignore changes on op outside DECODE, MEMADR and the immsrc decode.

Reset
REQ-030 SHALL force state=FETCH and illegal=0 asynchronously while rst=0.
REQ-031 SHALL deassert memwrite, regwrite and pcwrite in the same instant reset asserts mid-instruction.
REQ-032 SHALL begin the first FETCH on the first rising clk after rst deasserts.

Structure
REQ-033 SHALL place the state encodings (4-bit) and opcode constants in a shared package, riscv_ctrl_pkg, used by the datapath bench.
REQ-034 SHALL split into the FSM (state register + next-state) and one combinational sub-module, mc_ctrl_word, that maps state and mem_ready to the control word.

Verification
REQ-035 SHALL check: lw (op=0000011) with mem_ready=1 -> state sequence F,D,MA,MR,MWB,F; regwrite=1 only in cycle 5 with resultsrc=01.
REQ-036 SHALL check: sw with mem_ready=0 for 3 cycles in MEMWRITE -> memwrite=1 for 4 cycles, then FETCH; regwrite never asserted.
REQ-037 SHALL check: beq with zero=1 -> pcwrite=1 in BEQ; with zero=0 -> pcwrite=0; 3-cycle latency in both cases.
REQ-038 SHALL check: op=1111111 -> ILLEGAL after DECODE; illegal=1 and all enables 0 for 20 cycles; rst pulse clears it to FETCH.
REQ-039 SHALL check: rst asserted while in MEMWRITE -> memwrite drops to 0 before the next clk edge; state=FETCH.
REQ-040 SHALL check: jal -> JAL then ALUWB, pcwrite=1 in JAL, immsrc=11, regwrite=1 in ALUWB.
